// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {PC, Instr} pairs whose head
// drives the decode-stage bus; a redirect flushes every buffered entry in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            InstrF,
    input  logic [31:0]            PCF,
    input  logic                   FetchValidF,
    output logic                   FetchReadyF,
    input  logic                   StallD,
    input  logic                   FlushD,
    output logic [31:0]            InstrD,
    output logic [31:0]            PCD,
    output logic [31:0]            PCPlus4D,
    output logic                   ValidD,
    output logic [$clog2(DEPTH):0] CountD
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic          head_valid;

    // Readiness and head visibility depend only on registered occupancy.
    assign head_valid  = (count_q != '0);
    assign FetchReadyF = (count_q < CW'(DEPTH));

    // Pointer and occupancy update; flush collapses the queue and beats push/pop.
    always_comb begin
        push     = FetchValidF & FetchReadyF & ~FlushD;
        pop      = head_valid & ~StallD & ~FlushD;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= InstrF;
            pc_q[wr_ptr_q]    <= PCF;
        end
    end

    always_comb begin
        ValidD   = head_valid;
        InstrD   = head_valid ? instr_q[rd_ptr_q] : NOP;
        PCD      = head_valid ? pc_q[rd_ptr_q] : 32'h0;
        PCPlus4D = head_valid ? (pc_q[rd_ptr_q] + 32'd4) : 32'h0;
        CountD   = count_q;
    end

endmodule
